// File: rtl/lsu_axi_master_pkg.sv
// Shared types and constants for the LSU AXI4-Lite master.
`timescale 1ns/1ps
package axi_master_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_WR,
        S_B,
        S_RSP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Anything other than OKAY is reported to the core as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/lsu_axi_master_if.sv
// AXI4-Lite bus bundle with handshake "fire" strobes derived inside the interface.
`timescale 1ns/1ps
interface AXI4_Lite #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;

    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;

    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;

    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;

    logic ar_fire;
    logic aw_fire;
    logic w_fire;
    logic r_fire;
    logic b_fire;

    assign ar_fire = arvalid && arready;
    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid  && wready;
    assign r_fire  = rvalid  && rready;
    assign b_fire  = bvalid  && bready;

    modport master (
        output arvalid, araddr, arprot, awvalid, awaddr, awprot,
               wvalid, wdata, wstrb, rready, bready,
        input  arready, awready, wready, rvalid, rdata, rresp, bvalid, bresp,
               ar_fire, aw_fire, w_fire, r_fire, b_fire
    );

    modport slave (
        input  arvalid, araddr, arprot, awvalid, awaddr, awprot,
               wvalid, wdata, wstrb, rready, bready,
               ar_fire, aw_fire, w_fire, r_fire, b_fire,
        output arready, awready, wready, rvalid, rdata, rresp, bvalid, bresp
    );

endinterface

// File: rtl/lsu_axi_master.sv
// Single-outstanding load/store to AXI4-Lite bridge; one response per core request.
`timescale 1ns/1ps
import axi_master_pkg::*;

module lsu_axi_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wmask,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    AXI4_Lite.master            m_axi
);

    localparam int STRB_W = DATA_W / 8;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wmask_q, wmask_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;

    // State and captured request/response registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Next-state and register updates driven by request and AXI handshakes.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        unique case (state_q)
            S_IDLE: begin
                // req_ready is high here, so req_valid alone is the accept.
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                    state_d = req_we ? S_WR : S_AR;
                end
            end
            S_AR: begin
                if (m_axi.ar_fire) state_d = S_R;
            end
            S_R: begin
                if (m_axi.r_fire) begin
                    rdata_d = m_axi.rdata;
                    err_d   = resp_is_err(m_axi.rresp);
                    state_d = S_RSP;
                end
            end
            S_WR: begin
                // AW and W may complete in either order or together.
                aw_done_d = aw_done_q || m_axi.aw_fire;
                w_done_d  = w_done_q  || m_axi.w_fire;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_B;
                end
            end
            S_B: begin
                if (m_axi.b_fire) begin
                    rdata_d = '0;
                    err_d   = resp_is_err(m_axi.bresp);
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state only, so no AXI input reaches an AXI output.
    always_comb begin
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_rdata     = rdata_q;
        rsp_err       = err_q;
        m_axi.arvalid = 1'b0;
        m_axi.araddr  = addr_q;
        m_axi.arprot  = 3'b000;
        m_axi.awvalid = 1'b0;
        m_axi.awaddr  = addr_q;
        m_axi.awprot  = 3'b000;
        m_axi.wvalid  = 1'b0;
        m_axi.wdata   = wdata_q;
        m_axi.wstrb   = wmask_q;
        m_axi.rready  = 1'b0;
        m_axi.bready  = 1'b0;
        unique case (state_q)
            S_IDLE: req_ready     = 1'b1;
            S_AR:   m_axi.arvalid = 1'b1;
            S_R:    m_axi.rready  = 1'b1;
            S_WR: begin
                m_axi.awvalid = !aw_done_q;
                m_axi.wvalid  = !w_done_q;
            end
            S_B:    m_axi.bready  = 1'b1;
            S_RSP:  rsp_valid     = 1'b1;
            default: req_ready    = 1'b0;
        endcase
    end

endmodule
